// File: rtl/config_packet_responder.sv
// -----------------------------------------------------------------------------
// config_packet_responder
//
// Chip-side responder for the 64-bit configuration protocol. Words are pulled
// one at a time from the UART receiver. Each word has its odd parity, declare
// field, magic number and chip ID checked. Addressed writes and reads go to
// the register map. The responder then returns an echo word (write) or a
// read-reply word (read) to the UART transmitter. Data packets and packets for
// other chips are forwarded unchanged.
//
// Packet field map:
//   [1:0]   declare  (0 = invalid, 1 = data, 2 = write, 3 = read)
//   [9:2]   chip ID
//   [17:10] register address
//   [25:18] data
//   [57:26] magic number
//   [62]    reply marker
//   [63]    parity (odd over [63:0])
//
// Ports:
//   clk             core clock
//   reset_n         synchronous active-low reset
//   chip_id         this chip's ID
//   rx_data         word from the UART receiver
//   rx_empty        low while the receiver holds an unread word
//   uld_rx_data     one-cycle unload strobe to the receiver
//   regmap_addr     register-map address
//   regmap_wr_data  register-map write data
//   regmap_we       one-cycle register-map write enable
//   regmap_rd_data  register-map read data, valid 1 cycle after regmap_addr
//   tx_data         reply/forward word to the UART transmitter
//   ld_tx_data      one-cycle load strobe to the transmitter
//   tx_busy         transmitter busy
//   parity_err_cnt  saturating count of parity failures
//   proto_err_cnt   saturating count of declare==0 / bad-magic drops
// -----------------------------------------------------------------------------
module config_packet_responder #(
    parameter int          WIDTH        = 64,
    parameter int          REGNUM       = 256,
    parameter int          GLOBAL_ID    = 255,
    parameter logic [31:0] MAGIC_NUMBER = 32'h89504E47
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       chip_id,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_empty,
    output logic             uld_rx_data,
    output logic [7:0]       regmap_addr,
    output logic [7:0]       regmap_wr_data,
    output logic             regmap_we,
    input  logic [7:0]       regmap_rd_data,
    output logic [WIDTH-1:0] tx_data,
    output logic             ld_tx_data,
    input  logic             tx_busy,
    output logic [7:0]       parity_err_cnt,
    output logic [7:0]       proto_err_cnt
);

    localparam logic [7:0] GLOBAL_ID_8 = GLOBAL_ID[7:0];

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WRITE,
        ST_READ1,
        ST_READ2,
        ST_SEND
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pkt;
    logic [WIDTH-1:0] r_reply;
    logic [WIDTH-1:0] r_tx_data;
    logic             r_uld;
    logic             r_ld;
    logic             r_we;
    logic [7:0]       r_addr;
    logic [7:0]       r_wr_data;
    logic [7:0]       r_par_cnt;
    logic [7:0]       r_proto_cnt;

    // Field decode of the latched packet.
    logic [1:0]       w_declare;
    logic [7:0]       w_chip;
    logic [7:0]       w_addr;
    logic [7:0]       w_data;
    logic [31:0]      w_magic;
    logic             w_parity_ok;
    logic             w_magic_ok;
    logic             w_addressed;
    logic             w_addr_ok;
    logic [WIDTH-1:0] w_wr_reply;
    logic [WIDTH-1:0] w_rd_reply;

    assign w_declare   = r_pkt[1:0];
    assign w_chip      = r_pkt[9:2];
    assign w_addr      = r_pkt[17:10];
    assign w_data      = r_pkt[25:18];
    assign w_magic     = r_pkt[57:26];
    // Odd parity: the XOR of all 64 bits must be 1.
    assign w_parity_ok = ^r_pkt;
    assign w_magic_ok  = (w_magic == MAGIC_NUMBER);
    assign w_addressed = (w_chip == chip_id) || (w_chip == GLOBAL_ID_8);
    assign w_addr_ok   = ({24'd0, w_addr} < REGNUM);

    // Replies always carry our own chip ID (even for broadcast requests) and
    // the marker bit. Parity is regenerated because those fields changed.
    always_comb begin
        w_wr_reply        = r_pkt;
        w_wr_reply[62]    = 1'b1;
        w_wr_reply[9:2]   = chip_id;
        w_wr_reply[63]    = ~^w_wr_reply[62:0];

        w_rd_reply        = r_pkt;
        w_rd_reply[62]    = 1'b1;
        w_rd_reply[9:2]   = chip_id;
        w_rd_reply[25:18] = regmap_rd_data;
        w_rd_reply[63]    = ~^w_rd_reply[62:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_pkt       <= '0;
            r_reply     <= '0;
            r_tx_data   <= '0;
            r_uld       <= 1'b0;
            r_ld        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wr_data   <= '0;
            r_par_cnt   <= '0;
            r_proto_cnt <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_uld <= 1'b0;
            r_ld  <= 1'b0;
            r_we  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Only one packet is in flight. Later words wait in the
                    // receiver until we return here.
                    if (!rx_empty) begin
                        r_uld   <= 1'b1;
                        r_pkt   <= rx_data;
                        r_state <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (!w_parity_ok) begin
                        if (r_par_cnt != 8'hFF) begin
                            r_par_cnt <= r_par_cnt + 8'd1;
                        end
                        r_state <= ST_IDLE;
                    end else if (w_declare == 2'd0) begin
                        if (r_proto_cnt != 8'hFF) begin
                            r_proto_cnt <= r_proto_cnt + 8'd1;
                        end
                        r_state <= ST_IDLE;
                    end else if (w_declare == 2'd1) begin
                        // Data packet: pass through bit-exact.
                        r_reply <= r_pkt;
                        r_state <= ST_SEND;
                    end else if (!w_magic_ok) begin
                        if (r_proto_cnt != 8'hFF) begin
                            r_proto_cnt <= r_proto_cnt + 8'd1;
                        end
                        r_state <= ST_IDLE;
                    end else if (!w_addressed) begin
                        // Someone else's config packet: pass along, original parity.
                        r_reply <= r_pkt;
                        r_state <= ST_SEND;
                    end else if (!w_addr_ok) begin
                        r_state <= ST_IDLE;
                    end else if (w_declare == 2'd2) begin
                        // The write strobe is registered here so it is high
                        // during the single WRITE cycle.
                        r_addr    <= w_addr;
                        r_wr_data <= w_data;
                        r_we      <= 1'b1;
                        r_reply   <= w_wr_reply;
                        r_state   <= ST_WRITE;
                    end else begin
                        r_addr  <= w_addr;
                        r_state <= ST_READ1;
                    end
                end

                ST_WRITE: begin
                    r_state <= ST_SEND;
                end

                // The address is presented in READ1. The map answers one cycle
                // later, so data is captured at the end of READ2.
                ST_READ1: begin
                    r_state <= ST_READ2;
                end

                ST_READ2: begin
                    r_reply <= w_rd_reply;
                    r_state <= ST_SEND;
                end

                ST_SEND: begin
                    if (!tx_busy) begin
                        r_ld      <= 1'b1;
                        r_tx_data <= r_reply;
                        r_state   <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign uld_rx_data    = r_uld;
    assign regmap_addr    = r_addr;
    assign regmap_wr_data = r_wr_data;
    assign regmap_we      = r_we;
    assign tx_data        = r_tx_data;
    assign ld_tx_data     = r_ld;
    assign parity_err_cnt = r_par_cnt;
    assign proto_err_cnt  = r_proto_cnt;

endmodule

// File: doc/config_packet_responder.md
Name: config_packet_responder

Overview:
- Chip-side responder for the 64-bit configuration protocol driven by the FPGA master.
- Takes words unloaded from the chip's UART receiver, checks parity and magic number, and matches chip ID (own or broadcast).
- Performs register-map writes and reads, then returns an echo or read-reply word to the UART transmitter.
- Forwards non-addressed and data packets unchanged.

Parameters:
- WIDTH, 64, packet width including parity bit [63].
- REGNUM, 256, register-map depth; addresses >= REGNUM are ignored.
- GLOBAL_ID, 255, broadcast chip ID.
- MAGIC_NUMBER, 32'h89504E47, required value of bits [57:26] on config packets.

Ports:
- clk  input  1  core clock
- reset_n  input  1  synchronous active-low reset
- chip_id  input  8  this chip's ID
- rx_data  input  64  word from UART receiver
- rx_empty  input  1  low = receiver holds an unread word
- uld_rx_data  output  1  one-cycle unload strobe to receiver
- regmap_addr  output  8  register-map address
- regmap_wr_data  output  8  write data
- regmap_we  output  1  one-cycle write enable
- regmap_rd_data  input  8  read data, valid 1 cycle after regmap_addr
- tx_data  output  64  word to UART transmitter
- ld_tx_data  output  1  one-cycle load strobe
- tx_busy  input  1  transmitter busy
- parity_err_cnt  output  8  saturating parity-error count
- proto_err_cnt  output  8  saturating count of declare==0 or bad-magic drops

Behaviour:
- Reset (reset_n low at a clk edge):
  - All outputs go to 0, FSM goes to IDLE, both counters clear.
  - Reset mid-packet abandons the packet: no write and no transmit occur.
- Field map:
  - declare [1:0], chip [9:2], addr [17:10], data [25:18], magic [57:26], marker [62], parity [63].
  - Parity is odd over [63:0].
- IDLE:
  - If rx_empty==0, pulse uld_rx_data for 1 cycle, latch rx_data on the same edge, go to CHECK.
- CHECK, 1 cycle:
  - Parity bad: parity_err_cnt++ (saturate at 255), go to IDLE.
  - Else declare==0: proto_err_cnt++, go to IDLE.
  - Else declare==1 (data packet): copy the word to the reply register unchanged, go to SEND.
  - Else declare 2/3 with magic != MAGIC_NUMBER: proto_err_cnt++, go to IDLE.
  - Else chip field != chip_id and != GLOBAL_ID: forward unchanged, go to SEND.
  - Else addr >= REGNUM: drop silently, go to IDLE.
  - Else declare==2: go to WRITE. Else declare==3: go to READ.
- WRITE:
  - regmap_addr=addr, regmap_wr_data=data, regmap_we=1 for exactly 1 cycle.
  - Reply = received word with marker=1, chip field=chip_id, parity recomputed. Go to SEND.
- READ:
  - Drive regmap_addr for 2 cycles; capture regmap_rd_data in the 2nd cycle.
  - Reply = word with data field=captured value, marker=1, chip field=chip_id, parity recomputed. Go to SEND.
- SEND:
  - Wait until tx_busy==0, then pulse ld_tx_data for 1 cycle with tx_data holding the reply.
  - tx_data holds the reply until the next load. Go to IDLE.
- Rules:
  - Broadcast writes and reads are always executed and always replied with the own chip_id.
  - Forwarded words retain their original parity.
  - Only one packet is in flight at a time; new words wait in the receiver (rx_empty stays low).
  - Latency from uld strobe to ld_tx_data with tx idle: write 3 cycles, read 4 cycles, forward 2 cycles.
  - uld_rx_data and ld_tx_data are never asserted in the same cycle.

Test Plan:
- Write, chip_id=16, packet chip=16 addr=5 data=0xA5, valid magic and parity:
  - regmap_we pulses once with addr 5 / data 0xA5.
  - ld_tx_data word equals the input with [62]=1 and odd parity.
- Read, regmap[5]=0x3C, packet declare=3 chip=255 addr=5:
  - Reply data field=0x3C, chip field=16, marker=1, parity odd.
  - No regmap_we.
- Parity bit flipped on a valid write:
  - No regmap_we, no ld_tx_data, parity_err_cnt 0→1.
  - Repeat 300×: counter holds at 255.
- Bad traffic:
  - declare=0 → proto_err_cnt +1.
  - Magic 0xDEADBEEF → proto_err_cnt +1.
  - Packet chip=31 → forwarded bit-exact.
  - Data packet declare=1 → forwarded bit-exact.
- Flow control:
  - tx_busy held high 50 cycles during a reply: ld_tx_data fires on the first cycle tx_busy==0.
  - A second queued packet is not unloaded until the first reply loads.
- Reset during a READ (reset_n low 1 cycle):
  - All outputs 0, no ld_tx_data.
  - The next valid write is processed normally.
